card_dealer: RTL and testbench

Card source for the ten-thirty game: answers each deal request on `pip` with one card rank (1–13) on `number`, drawn without replacement from a 52-card deck (4 suits × 13 ranks). It sits on the game controller's slow control clock, at the other end of the `pip`/`number` deal interface. The game logic consumes any nonzero `number` as exactly one new card.

---
 rtl/card_dealer.sv | 111 +++++++++++
 tb/tb_card_dealer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// Ten-thirty card source: deals one rank (1..13) per pip rising edge from a
// 52-card deck without replacement, auto-refilling when the deck runs out.
module card_dealer #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pip,
  input  logic       reshuffle,
  output logic [3:0] number,
  output logic [5:0] deck_left,
  output logic       deck_empty
);

  localparam int unsigned NRANK  = 13;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned RANK_W = 4;
  localparam int unsigned LEFT_W = 6;

  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(4);
  localparam logic [LEFT_W-1:0] DECK_SIZE = LEFT_W'(52);
  localparam logic [RANK_W-1:0] MAX_RANK  = RANK_W'(13);

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    SEARCH,
    DEAL
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q [NRANK];
  logic [7:0]          lfsr_q;
  logic                pip_q;
  logic [RANK_W-1:0]   rank_q;
  logic [RANK_W-1:0]   number_q;
  logic [LEFT_W-1:0]   left_q;
  logic                empty_q;

  logic                lfsr_fb;
  logic                req;
  logic [RANK_W-1:0]   lfsr_low;
  logic [RANK_W-1:0]   cand;
  logic [RANK_W-1:0]   rank_idx;
  logic [RANK_W-1:0]   rank_next;

  // x^8+x^6+x^5+x^4+1 feedback into bit 0
  assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign req       = pip & ~pip_q;
  assign lfsr_low  = lfsr_q[3:0];
  assign cand      = (lfsr_low >= MAX_RANK) ? RANK_W'(lfsr_low - MAX_RANK + RANK_W'(1))
                                            : RANK_W'(lfsr_low + RANK_W'(1));
  assign rank_idx  = RANK_W'(rank_q - RANK_W'(1));
  assign rank_next = (rank_q == MAX_RANK) ? RANK_W'(1) : RANK_W'(rank_q + RANK_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      pip_q    <= 1'b0;
      rank_q   <= RANK_W'(1);
      number_q <= '0;
      left_q   <= DECK_SIZE;
      empty_q  <= 1'b0;
      for (int i = 0; i < NRANK; i++) cnt_q[i] <= FULL_CNT;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
      pip_q  <= pip;
      case (state_q)
        IDLE: begin
          if (req) begin
            rank_q  <= cand;
            state_q <= (left_q == '0 || reshuffle) ? REFILL : SEARCH;
          end else if (reshuffle) begin
            for (int i = 0; i < NRANK; i++) cnt_q[i] <= FULL_CNT;
            left_q  <= DECK_SIZE;
            empty_q <= 1'b0;
          end
        end
        REFILL: begin
          for (int i = 0; i < NRANK; i++) cnt_q[i] <= FULL_CNT;
          left_q  <= DECK_SIZE;
          empty_q <= 1'b0;
          state_q <= SEARCH;
        end
        SEARCH: begin
          // Walk upward (wrapping) until a rank with cards left is found
          if (cnt_q[rank_idx] != '0) begin
            number_q          <= rank_q;
            cnt_q[rank_idx]   <= CNT_W'(cnt_q[rank_idx] - CNT_W'(1));
            left_q            <= LEFT_W'(left_q - LEFT_W'(1));
            empty_q           <= (left_q == LEFT_W'(1));
            state_q           <= DEAL;
          end else begin
            rank_q <= rank_next;
          end
        end
        DEAL: begin
          number_q <= '0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign number     = number_q;
  assign deck_left  = left_q;
  assign deck_empty = empty_q;

endmodule

// File: tb/tb_card_dealer.sv
// Randomised scoreboard bench for card_dealer: a deck-level reference model
// predicts every dealt card, its output cycle and the deck count after it.
module tb_card_dealer;

  localparam logic [7:0] SEED = 8'hA5;
  localparam int DRAIN_MAX = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pip = 1'b0;
  logic       reshuffle = 1'b0;
  logic [3:0] number;
  logic [5:0] deck_left;
  logic       deck_empty;

  card_dealer #(.SEED(SEED)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pip       (pip),
    .reshuffle (reshuffle),
    .number    (number),
    .deck_left (deck_left),
    .deck_empty(deck_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rank;
    int cyc;
    int left;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         idle_at = 0;
  int         n_dealt = 0;
  int         last_deal_cyc = 0;
  int         hist[16];
  int         m_cnt[14];
  int         m_left = 52;
  logic [7:0] m_lfsr = SEED;
  logic       m_pip_prev = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_refill();
    for (int r = 1; r <= 13; r++) m_cnt[r] = 4;
    m_left = 52;
  endtask

  // Deck-level prediction of one deal request sampled at edge 'cyc'
  task automatic model_request();
    int   c;
    int   rk;
    int   r;
    int   s;
    exp_t e;
    c = int'(m_lfsr[3:0]);
    if (c >= 13) c -= 13;
    rk = c + 1;
    r = (m_left == 0 || reshuffle) ? 1 : 0;
    if (r == 1) model_refill();
    s = 0;
    while (m_cnt[rk] == 0 && s < 13) begin
      rk = (rk == 13) ? 1 : rk + 1;
      s++;
    end
    m_cnt[rk]--;
    m_left--;
    e.rank = rk;
    e.cyc  = cyc + 1 + r + s;
    e.left = m_left;
    exp_q.push_back(e);
    idle_at = cyc + 3 + r + s;
  endtask

  // Reference model: advances once per clock edge, cleared by reset
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_lfsr     = SEED;
        m_pip_prev = 1'b0;
        model_refill();
        idle_at    = 0;
        cyc        = 0;
        exp_q.delete();
      end else begin
        cyc++;
        if (cyc >= idle_at) begin
          if (pip && !m_pip_prev) model_request();
          else if (reshuffle) model_refill();
        end
        m_pip_prev = pip;
        m_lfsr     = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      end
    end
  end

  // Monitor: pops the scoreboard whenever a card appears
  initial begin
    logic prev_nz;
    exp_t e;
    prev_nz = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_nz = 1'b0;
        continue;
      end
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check("missing_card", 0, e.rank);
      end
      if (number != 4'd0) begin
        n_dealt++;
        last_deal_cyc = cyc;
        hist[int'(number)]++;
        check("pulse_width_1", int'(prev_nz), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_card", int'(number), 0);
        end else begin
          e = exp_q.pop_front();
          check("card_rank", int'(number), e.rank);
          check("card_cycle", cyc, e.cyc);
          check("card_deck_left", int'(deck_left), e.left);
          check("card_deck_empty", int'(deck_empty), (e.left == 0) ? 1 : 0);
        end
      end
      prev_nz = (number != 4'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_pip();
    pip = 1'b1;
    tick(1);
    pip = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < DRAIN_MAX) begin
      tick(1);
      t++;
    end
    check("drain_pending", exp_q.size(), 0);
    tick(2);
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 16; i++) hist[i] = 0;
  endtask

  task automatic check_hist(input string name);
    for (int r = 1; r <= 13; r++) check(name, hist[r], 4);
  endtask

  task automatic deal_spaced(input int n);
    for (int i = 0; i < n; i++) begin
      pulse_pip();
      tick(19);
    end
    drain();
  endtask

  initial begin
    int d0;
    int t0;
    clear_hist();

    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("reset_number", int'(number), 0);
    check("reset_deck_left", int'(deck_left), 52);
    check("reset_deck_empty", int'(deck_empty), 0);
    tick(10);
    check("no_card_before_pip", n_dealt, 0);

    d0 = n_dealt;
    pip = 1'b1;
    tick(40);
    pip = 1'b0;
    drain();
    check("held_pip_deals", n_dealt - d0, 1);
    check("held_pip_deck_left", int'(deck_left), 51);

    reshuffle = 1'b1;
    tick(1);
    reshuffle = 1'b0;
    check("idle_reshuffle_52", int'(deck_left), 52);

    clear_hist();
    deal_spaced(52);
    check_hist("full_deck_rank_count");
    check("full_deck_left", int'(deck_left), 0);
    check("full_deck_empty", int'(deck_empty), 1);

    d0 = n_dealt;
    t0 = cyc;
    pulse_pip();
    drain();
    check("refill_deals", n_dealt - d0, 1);
    check("refill_latency_ge3", (last_deal_cyc - t0 >= 3) ? 1 : 0, 1);
    check("refill_deck_left", int'(deck_left), 51);
    check("refill_deck_empty", int'(deck_empty), 0);

    deal_spaced(9);
    check("pre_reshuffle_42", int'(deck_left), 42);
    reshuffle = 1'b1;
    tick(1);
    reshuffle = 1'b0;
    check("reshuffle_to_52", int'(deck_left), 52);

    pip = 1'b1;
    tick(1);
    pip = 1'b0;
    reshuffle = 1'b1;
    tick(1);
    reshuffle = 1'b0;
    drain();
    check("busy_reshuffle_ignored", int'(deck_left), 51);

    for (int i = 0; i < 1500; i++) begin
      pip       = ($urandom_range(0, 5) == 0);
      reshuffle = ($urandom_range(0, 40) == 0);
      tick(1);
    end
    pip = 1'b0;
    reshuffle = 1'b0;
    drain();
    check("random_deck_left", int'(deck_left), m_left);
    check("random_deck_empty", int'(deck_empty), (m_left == 0) ? 1 : 0);

    d0 = n_dealt;
    pip = 1'b1;
    tick(1);
    pip = 1'b0;
    rst_n = 1'b0;
    tick(2);
    check("midsearch_rst_number", int'(number), 0);
    check("midsearch_rst_left", int'(deck_left), 52);
    rst_n = 1'b1;
    tick(20);
    check("midsearch_no_card", n_dealt - d0, 0);
    clear_hist();
    deal_spaced(52);
    check_hist("post_reset_rank_count");
    check("post_reset_empty", int'(deck_empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
